// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational IMEM and
// presents the word to decode through a valid/ready IF/ID register.
module if_stage #(
    parameter int unsigned          PC_WIDTH     = 10,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
    parameter bit                   HALT_ON_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] imem_pc,
    input  logic [31:0]         imem_inst,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [31:0]         id_inst,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [PC_WIDTH-1:0] id_pc_plus4,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] PC_ALIGN = ~PC_WIDTH'(3);

    state_t              state;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] redirect_aligned;
    logic                adv;
    logic                zero_word;

    assign imem_pc          = pc_q;
    assign pc_next          = pc_q + PC_STEP;
    assign redirect_aligned = redirect_pc & PC_ALIGN;
    assign adv              = !id_valid || id_ready;
    assign zero_word        = HALT_ON_ZERO && (imem_inst == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            id_valid    <= 1'b0;
            id_inst     <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            // A handshake counts even when a redirect flushes on the same edge.
            if (id_valid && id_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end

            case (state)
                BOOT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_aligned;
                    end
                    state <= RUN;
                end

                RUN: begin
                    if (redirect_valid) begin
                        pc_q     <= redirect_aligned;
                        id_valid <= 1'b0;
                    end else if (adv && zero_word) begin
                        // pc_q stays on the zero word so the halt address is visible.
                        id_valid <= 1'b0;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else if (adv) begin
                        id_inst     <= imem_inst;
                        id_pc       <= pc_q;
                        id_pc_plus4 <= pc_next;
                        id_valid    <= 1'b1;
                        pc_q        <= pc_next;
                    end
                end

                HALT: begin
                    id_valid <= 1'b0;
                    if (redirect_valid) begin
                        pc_q   <= redirect_aligned;
                        halted <= 1'b0;
                        state  <= RUN;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule
